// File: rtl/fir_config_sequencer.sv
// fir_config_sequencer
//   Front-end controller for a 7-tap FIR filter. Keeps a host-writable
//   shadow of the tap weights, streams them into the filter over a
//   valid/ready weight port, gates the sample stream so samples only reach
//   the filter while a full weight set is loaded, and drains in-flight
//   samples before a reload.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no weights loaded, sample stream closed, waiting cfg_start
//   ST_LOAD  | offering shadow[tap_q] to the filter, stream closed
//   ST_RUN   | weights loaded, sample stream open (bounded by in-flight)
//   ST_DRAIN | reload requested, stream closed until in-flight reaches 0

module fir_config_sequencer #(
  parameter int TAPS         = 7,
  parameter int DATA_W       = 8,
  parameter int IDX_W        = 3,
  parameter int MAX_INFLIGHT = 15,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  // shadow weight configuration
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              cfg_start,
  // status
  output logic              busy,
  output logic              running,
  output logic              cfg_done,
  // weight port towards the filter
  output logic              fir_weight_valid,
  input  logic              fir_weight_ready,
  output logic [IDX_W-1:0]  fir_weight_idx,
  output logic [DATA_W-1:0] fir_weight_data,
  // sample stream
  input  logic              src_valid,
  output logic              src_ready,
  output logic              fir_input_valid,
  input  logic              fir_input_ready,
  input  logic              fir_output_valid,
  input  logic              fir_output_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);
  localparam logic [IDX_W:0]   TAPS_EXT = (IDX_W + 1)'(TAPS);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_INFLIGHT);

  state_t              state_q;
  logic [IDX_W-1:0]    tap_q;
  logic                cfg_done_q;
  logic [CNT_W-1:0]    inflight_q;
  logic [CNT_W-1:0]    inflight_d;
  logic [DATA_W-1:0]   shadow_q [TAPS];

  logic                gate_open;
  logic                in_hs;
  logic                out_hs;
  logic                shadow_wr;

  // Sample gate: open only in RUN and only while the filter has room for
  // another in-flight sample, so the counter can never pass MAX_INFLIGHT.
  assign gate_open       = (state_q == ST_RUN) && (inflight_q < MAX_CNT);
  assign fir_input_valid = src_valid & gate_open;
  assign src_ready       = fir_input_ready & gate_open;

  assign in_hs  = src_valid & src_ready;
  assign out_hs = fir_output_valid & fir_output_ready;

  assign fir_weight_valid = (state_q == ST_LOAD);
  assign fir_weight_idx   = tap_q;
  assign fir_weight_data  = shadow_q[tap_q];

  assign busy     = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign running  = (state_q == ST_RUN);
  assign cfg_done = cfg_done_q;

  assign shadow_wr = cfg_we && ({1'b0, cfg_addr} < TAPS_EXT);

  // Shadow weight store: host writes land at the next edge in any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (shadow_wr) begin
      shadow_q[cfg_addr] <= cfg_wdata;
    end
  end

  // In-flight next value; an output with nothing outstanding is a filter
  // protocol violation and is absorbed at zero rather than wrapping.
  always_comb begin
    inflight_d = inflight_q;
    if (in_hs && !out_hs) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!in_hs && out_hs && (inflight_q != '0)) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  // In-flight counter, tracked in every state so outputs drain anywhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  // Sequencer FSM with registered tap counter and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      tap_q      <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      cfg_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            state_q <= ST_LOAD;
            tap_q   <= '0;
          end
        end
        ST_LOAD: begin
          if (fir_weight_ready) begin
            if (tap_q == LAST_TAP) begin
              state_q    <= ST_RUN;
              tap_q      <= '0;
              cfg_done_q <= 1'b1;
            end else begin
              tap_q <= tap_q + IDX_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (cfg_start) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (inflight_q == '0) begin
            state_q <= ST_LOAD;
            tap_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tap_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_config_sequencer.sv
// Bench for fir_config_sequencer: directed scenarios plus a random phase,
// every cycle compared against a count-based behavioural model.

module tb_fir_config_sequencer;

  localparam int TAPS         = 7;
  localparam int DATA_W       = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_INFLIGHT = 15;
  localparam int CNT_W        = 4;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              cfg_start;
  logic              busy;
  logic              running;
  logic              cfg_done;
  logic              fir_weight_valid;
  logic              fir_weight_ready;
  logic [IDX_W-1:0]  fir_weight_idx;
  logic [DATA_W-1:0] fir_weight_data;
  logic              src_valid;
  logic              src_ready;
  logic              fir_input_valid;
  logic              fir_input_ready;
  logic              fir_output_valid;
  logic              fir_output_ready;

  fir_config_sequencer #(
    .TAPS(TAPS), .DATA_W(DATA_W), .IDX_W(IDX_W),
    .MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_start(cfg_start),
    .busy(busy), .running(running), .cfg_done(cfg_done),
    .fir_weight_valid(fir_weight_valid), .fir_weight_ready(fir_weight_ready),
    .fir_weight_idx(fir_weight_idx), .fir_weight_data(fir_weight_data),
    .src_valid(src_valid), .src_ready(src_ready),
    .fir_input_valid(fir_input_valid), .fir_input_ready(fir_input_ready),
    .fir_output_valid(fir_output_valid), .fir_output_ready(fir_output_ready)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase, load progress, totals of accepted/emitted
  // samples, and the expected weight contents.
  int          m_mode;
  int          m_tap;
  bit          m_done;
  int          m_acc;
  int          m_emit;
  logic [7:0]  m_shadow [TAPS];

  int checks = 0;
  int errors = 0;
  bit in_hs_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_tap  = 0;
    m_done = 0;
    m_acc  = 0;
    m_emit = 0;
    for (int i = 0; i < TAPS; i++) m_shadow[i] = 8'h00;
  endtask

  task automatic idle_inputs();
    cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; cfg_start = 0;
    fir_weight_ready = 0; src_valid = 0; fir_input_ready = 0;
    fir_output_valid = 0; fir_output_ready = 0;
  endtask

  task automatic check_outputs();
    bit open;
    open = (m_mode == M_RUN) && ((m_acc - m_emit) < MAX_INFLIGHT);
    chk("fir_input_valid", 32'(fir_input_valid), 32'(src_valid && open));
    chk("src_ready", 32'(src_ready), 32'(fir_input_ready && open));
    chk("fir_weight_valid", 32'(fir_weight_valid), 32'(m_mode == M_LOAD));
    chk("fir_weight_idx", 32'(fir_weight_idx), 32'(m_tap));
    chk("fir_weight_data", 32'(fir_weight_data), 32'(m_shadow[m_tap]));
    chk("busy", 32'(busy), 32'(m_mode == M_LOAD || m_mode == M_DRAIN));
    chk("running", 32'(running), 32'(m_mode == M_RUN));
    chk("cfg_done", 32'(cfg_done), 32'(m_done));
  endtask

  task automatic model_update();
    bit open, acc, emit;
    int pend;
    pend = m_acc - m_emit;
    open = (m_mode == M_RUN) && (pend < MAX_INFLIGHT);
    acc  = src_valid && fir_input_ready && open;
    emit = fir_output_valid && fir_output_ready && (pend > 0 || acc);
    m_done = 0;
    case (m_mode)
      M_IDLE:  if (cfg_start) begin m_mode = M_LOAD; m_tap = 0; end
      M_LOAD:  if (fir_weight_ready) begin
                 if (m_tap == TAPS - 1) begin m_mode = M_RUN; m_tap = 0; m_done = 1; end
                 else m_tap++;
               end
      M_RUN:   if (cfg_start) m_mode = M_DRAIN;
      default: if (pend == 0) begin m_mode = M_LOAD; m_tap = 0; end
    endcase
    if (acc)  m_acc++;
    if (emit) m_emit++;
    if (cfg_we && cfg_addr < TAPS) m_shadow[cfg_addr] = cfg_wdata;
  endtask

  // One clock: inputs were set by the caller after a falling edge.
  task automatic step();
    #1;
    in_hs_seen = src_valid && src_ready;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic int dut_mode();
    if (running)          return M_RUN;
    if (fir_weight_valid) return M_LOAD;
    if (busy)             return M_DRAIN;
    return M_IDLE;
  endfunction

  task automatic wait_mode(input int mode, input int budget, input string tag);
    int n = 0;
    while (m_mode != mode && n < budget) begin step(); n++; end
    chk(tag, 32'(dut_mode()), 32'(mode));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int acc_cnt;

    idle_inputs();
    model_reset();
    rst = 0;
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1;

    // Closed stream in IDLE.
    src_valid = 1; fir_input_ready = 1;
    repeat (10) step();
    idle_inputs();

    // Shadow 0..6 = 1..7, then load with ready held high.
    for (int a = 0; a < TAPS; a++) begin
      cfg_we = 1; cfg_addr = 3'(a); cfg_wdata = 8'(a + 1);
      step();
    end
    cfg_we = 0;
    cfg_start = 1;
    step();
    cfg_start = 0;
    fir_weight_ready = 1;
    n = 0;
    while (fir_weight_valid && n < 50) begin
      chk("load_idx_seq", 32'(fir_weight_idx), 32'(n));
      chk("load_data_seq", 32'(fir_weight_data), 32'(n + 1));
      step(); n++;
    end
    chk("load_len_ready", 32'(n), 32'(7));
    chk("cfg_done_first_run", 32'(cfg_done), 32'(1));
    fir_weight_ready = 0;
    step();

    // New random weights (addr 7 ignored), reload with ready toggling.
    for (int a = 0; a < 8; a++) begin
      cfg_we = 1; cfg_addr = 3'(a); cfg_wdata = 8'($urandom_range(255));
      step();
    end
    cfg_we = 0;
    cfg_start = 1;
    step();
    cfg_start = 0;
    step();
    n = 0;
    while (fir_weight_valid && n < 60) begin
      fir_weight_ready = (n % 2 == 1);
      step(); n++;
    end
    chk("load_len_toggle", 32'(n), 32'(14));
    fir_weight_ready = 0;
    step();

    // Five samples in flight, then drain before reload.
    src_valid = 1; fir_input_ready = 1;
    repeat (5) step();
    src_valid = 0;
    cfg_start = 1;
    step();
    cfg_start = 0;
    src_valid = 1;
    repeat (3) step();
    fir_output_valid = 1; fir_output_ready = 1;
    repeat (5) step();
    fir_output_valid = 0; fir_output_ready = 0;
    chk("drain_still_busy", 32'(dut_mode()), 32'(M_DRAIN));
    step();
    chk("load_after_drain", 32'(dut_mode()), 32'(M_LOAD));
    src_valid = 0;
    fir_weight_ready = 1;
    wait_mode(M_RUN, 40, "reach_run_1");
    step();

    // Fill to the in-flight limit with outputs blocked.
    src_valid = 1; fir_input_ready = 1;
    acc_cnt = 0;
    repeat (20) begin step(); if (in_hs_seen) acc_cnt++; end
    chk("fill_limit", 32'(acc_cnt), 32'(MAX_INFLIGHT));
    fir_output_valid = 1; fir_output_ready = 1;
    step();
    fir_output_valid = 0; fir_output_ready = 0;
    acc_cnt = 0;
    repeat (5) begin step(); if (in_hs_seen) acc_cnt++; end
    chk("refill_one", 32'(acc_cnt), 32'(1));
    src_valid = 0;
    fir_output_valid = 1; fir_output_ready = 1;
    repeat (16) step();

    // Spurious outputs with nothing outstanding must not wrap the counter.
    repeat (3) step();
    fir_output_valid = 0; fir_output_ready = 0;
    src_valid = 1;
    #1;
    chk("no_wrap_gate", 32'(src_ready), 32'(1));
    step();
    src_valid = 0;

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      cfg_we           = ($urandom_range(3) == 0);
      cfg_addr         = 3'($urandom_range(7));
      cfg_wdata        = 8'($urandom_range(255));
      cfg_start        = ($urandom_range(24) == 0);
      fir_weight_ready = ($urandom_range(2) != 0);
      src_valid        = ($urandom_range(1) == 1);
      fir_input_ready  = ($urandom_range(3) != 0);
      fir_output_valid = ((m_acc - m_emit) > 0) ? ($urandom_range(1) == 1)
                                                : ($urandom_range(15) == 0);
      fir_output_ready = ($urandom_range(3) != 0);
      step();
    end
    idle_inputs();

    // Make the shadow nonzero, then reset in the middle of a load at tap 3.
    for (int a = 0; a < TAPS; a++) begin
      cfg_we = 1; cfg_addr = 3'(a); cfg_wdata = 8'(8'hA5 ^ a);
      step();
    end
    cfg_we = 0;
    n = 0;
    while (!(m_mode == M_LOAD && m_tap == 3) && n < 200) begin
      cfg_start        = (m_mode == M_IDLE || m_mode == M_RUN);
      fir_weight_ready = 1;
      fir_output_valid = 1; fir_output_ready = 1;
      step(); n++;
    end
    idle_inputs();
    #1;
    chk("pre_reset_idx3", 32'(fir_weight_idx), 32'(3));
    chk("pre_reset_valid", 32'(fir_weight_valid), 32'(1));
    rst = 0;
    #1;
    chk("rst_weight_valid", 32'(fir_weight_valid), 32'(0));
    chk("rst_weight_idx", 32'(fir_weight_idx), 32'(0));
    chk("rst_weight_data", 32'(fir_weight_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    model_reset();
    @(negedge clk);
    rst = 1;
    step();
    chk("idle_after_reset", 32'(dut_mode()), 32'(M_IDLE));
    cfg_start = 1;
    step();
    cfg_start = 0;
    fir_weight_ready = 1;
    n = 0;
    while (fir_weight_valid && n < 20) begin
      chk("cleared_shadow", 32'(fir_weight_data), 32'(0));
      step(); n++;
    end
    chk("reload_after_reset", 32'(n), 32'(7));
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_config_sequencer.md
Name: fir_config_sequencer

Overview:
- Controller in front of the 7-tap FIR_Filter.
- Holds a host-writable shadow copy of the tap weights and sequences them into the filter over its weight_valid/weight_ready/weight_idx port.
- Gates the sample stream so inputs reach the filter only while a complete weight set is loaded.
- On a reconfiguration request, drains in-flight samples before reloading. The filter emits exactly one output per accepted input.

Parameters:
- TAPS, 7, number of filter taps / shadow entries.
- DATA_W, 8, weight width.
- IDX_W, 3, tap index width; must satisfy 2^IDX_W >= TAPS.
- MAX_INFLIGHT, 15, maximum accepted-but-not-emitted samples.
- CNT_W, 4, in-flight counter width; must satisfy 2^CNT_W > MAX_INFLIGHT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_we  in  1  shadow weight write strobe.
- cfg_addr  in  IDX_W  shadow write address.
- cfg_wdata  in  DATA_W  shadow write data.
- cfg_start  in  1  load/reload request; level sampled each cycle.
- busy  out  1  high in LOAD or DRAIN.
- running  out  1  high in RUN.
- cfg_done  out  1  one-cycle pulse when a load completes.
- fir_weight_valid  out  1  weight offered to filter.
- fir_weight_ready  in  1  filter accepts weight.
- fir_weight_idx  out  IDX_W  tap index being offered.
- fir_weight_data  out  DATA_W  shadow[fir_weight_idx].
- src_valid  in  1  upstream sample valid.
- src_ready  out  1  sample accepted by filter (gated).
- fir_input_valid  out  1  gated valid to filter.
- fir_input_ready  in  1  filter input ready.
- fir_output_valid  in  1  filter output valid (monitored only).
- fir_output_ready  in  1  downstream output ready (monitored only).

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all shadow entries 0, tap counter 0, in-flight counter 0. All outputs 0, including fir_weight_idx and fir_weight_data.
- Shadow writes: accepted in every state when cfg_we=1 and cfg_addr < TAPS. Writes with cfg_addr >= TAPS are ignored. The write takes effect at the next edge; fir_weight_data shows the old value in the write cycle.
- States are IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - Stream closed: fir_input_valid=0, src_ready=0.
  - cfg_start=1 -> LOAD with tap counter 0.
- LOAD:
  - fir_weight_valid=1, fir_weight_idx=tap counter, fir_weight_data=shadow[tap counter].
  - On valid&ready with counter < TAPS-1: counter increments.
  - On valid&ready with counter == TAPS-1: next state RUN, counter returns to 0, cfg_done=1 for exactly the first RUN cycle.
  - fir_weight_ready low: idx and data hold; no timeout.
  - cfg_start is ignored. Stream is closed.
- RUN:
  - Gate open: fir_input_valid = src_valid & (inflight < MAX_INFLIGHT); src_ready = fir_input_ready & (inflight < MAX_INFLIGHT). Both are combinational from registered state.
  - cfg_start=1 -> DRAIN. The gate stays open during the cycle cfg_start is sampled.
- DRAIN:
  - Stream closed.
  - When inflight == 0 -> LOAD (counter 0). If inflight is already 0 on entry, LOAD starts the following cycle.
  - cfg_start is ignored.
- In-flight counter:
  - +1 on an input handshake (src_valid & src_ready).
  - -1 on an output handshake (fir_output_valid & fir_output_ready).
  - Both in the same cycle: unchanged.
  - The counter never exceeds MAX_INFLIGHT; gating guarantees this.
  - An output handshake while inflight == 0 is a filter protocol violation: the counter holds at 0 and does not wrap.
  - The counter is updated in all states, so outputs still drain during LOAD and IDLE.
- Status outputs: busy = (state==LOAD) | (state==DRAIN); running = (state==RUN).
- Reset mid-operation: immediate return to the reset state. The weight load is abandoned and the shadow is cleared; the filter is reset alongside on the same rst.

Test Plan:
- Reset, then src_valid=1 held for 10 cycles with fir_input_ready=1 -> src_ready=0 and fir_input_valid=0 throughout; busy=0, running=0.
- Write shadow 0..6 = 1..7, pulse cfg_start, fir_weight_ready=1 -> 7 consecutive handshakes with idx 0..6 and data 1..7. cfg_done pulses once in the following cycle; running=1.
- Repeat the load with fir_weight_ready toggling every cycle -> idx/data hold while ready=0. Load takes 14 cycles and cfg_done pulses once.
- In RUN, accept 5 samples with fir_output_ready=0 (inflight=5), then cfg_start -> DRAIN with src_ready=0. Complete 5 output handshakes -> LOAD the cycle after inflight reaches 0.
- In RUN with src_valid=1 and fir_output_ready=0 -> exactly 15 samples accepted, then src_ready=0. One output handshake -> one more sample accepted.
- Assert rst=0 while LOAD is offering idx 3 -> fir_weight_valid=0, idx=0, data=0 immediately; after release the state is IDLE and shadow reads 0.
